hilo_acc: RTL and testbench

HILO_ACC -- requirements
Module: hilo_acc

---
 rtl/hilo_acc_pkg.sv | 31 +++
 rtl/hilo_acc_if.sv | 25 ++
 rtl/hilo_mul.sv | 19 +
 rtl/hilo_acc.sv | 88 ++++++++
 tb/tb_hilo_acc.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/hilo_acc_pkg.sv
// Shared core constants for the HI/LO multiply-accumulate unit:
// machine word width, op-code encoding and small op-decode helpers.
package hilo_acc_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_WLO   = 3'b001,
    OP_WHI   = 3'b010,
    OP_WBOTH = 3'b011,
    OP_MADD  = 3'b100,
    OP_MADDU = 3'b101,
    OP_MSUB  = 3'b110,
    OP_MSUBU = 3'b111
  } hilo_op_e;

  // Accumulate ops all have the top op bit set.
  function automatic logic op_is_acc(input hilo_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_sub(input hilo_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_is_signed(input hilo_op_e op);
    return op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/hilo_acc_if.sv
// Request channel into the HI/LO unit: valid/ready handshake, op code,
// write data and multiply operands.
interface hilo_acc_if
  import hilo_acc_pkg::*;
#(
  parameter int XLEN = WORD_W
) ();
  logic            req_valid;
  logic            req_ready;
  hilo_op_e        req_op;
  logic [XLEN-1:0] hi_i;
  logic [XLEN-1:0] lo_i;
  logic [XLEN-1:0] rs_i;
  logic [XLEN-1:0] rt_i;

  modport master (
    output req_valid, req_op, hi_i, lo_i, rs_i, rt_i,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, hi_i, lo_i, rs_i, rt_i,
    output req_ready
  );
endinterface

// File: rtl/hilo_mul.sv
// Combinational XLEN x XLEN -> 2*XLEN multiplier with selectable operand
// extension; kept separate so a DSP or multi-cycle version can drop in.
module hilo_mul #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  input  logic              i_signed,
  output logic [2*XLEN-1:0] o_prod
);
  logic [2*XLEN-1:0] w_a_ext;
  logic [2*XLEN-1:0] w_b_ext;

  // Extending to full width first makes the truncated unsigned product
  // equal the two's-complement signed product.
  assign w_a_ext = i_signed ? {{XLEN{i_a[XLEN-1]}}, i_a} : {{XLEN{1'b0}}, i_a};
  assign w_b_ext = i_signed ? {{XLEN{i_b[XLEN-1]}}, i_b} : {{XLEN{1'b0}}, i_b};
  assign o_prod  = w_a_ext * w_b_ext;
endmodule

// File: rtl/hilo_acc.sv
// Architectural HI/LO register pair with single-cycle writes and a
// two-stage multiply-accumulate (product register, then add/sub into HI:LO).
module hilo_acc
  import hilo_acc_pkg::*;
#(
  parameter int XLEN          = WORD_W,
  parameter int MUL_SIGNED_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  hilo_acc_if.slave       req,
  input  logic            flush,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            busy,
  output logic            acc_done
);
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_s1_vld;
  logic              r_s1_sub;
  logic [2*XLEN-1:0] r_s1_prod;
  logic              r_acc_done;

  logic              w_accept;
  logic              w_signed;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_hilo_nxt;

  assign req.req_ready = !r_s1_vld && !flush;
  assign w_accept      = req.req_valid && req.req_ready;
  assign w_signed      = (MUL_SIGNED_EN != 0) && op_is_signed(req.req_op);

  hilo_mul #(.XLEN(XLEN)) u_mul (
    .i_a      (req.rs_i),
    .i_b      (req.rt_i),
    .i_signed (w_signed),
    .o_prod   (w_prod)
  );

  always_comb begin
    w_hilo_nxt = {r_hi, r_lo} + r_s1_prod;
    if (r_s1_sub) w_hilo_nxt = {r_hi, r_lo} - r_s1_prod;
  end

  // Priority: reset, flush, stage-2 retire, then new acceptance.
  // Acceptance cannot coincide with flush or retire since ready is low then.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_sub   <= 1'b0;
      r_s1_prod  <= '0;
      r_acc_done <= 1'b0;
    end else begin
      r_acc_done <= 1'b0;
      if (flush) begin
        r_s1_vld <= 1'b0;
      end else if (r_s1_vld) begin
        {r_hi, r_lo} <= w_hilo_nxt;
        r_s1_vld     <= 1'b0;
        r_acc_done   <= 1'b1;
      end else if (w_accept) begin
        case (req.req_op)
          OP_WLO:   r_lo <= req.lo_i;
          OP_WHI:   r_hi <= req.hi_i;
          OP_WBOTH: begin
            r_hi <= req.hi_i;
            r_lo <= req.lo_i;
          end
          default: begin
            if (op_is_acc(req.req_op)) begin
              r_s1_vld  <= 1'b1;
              r_s1_sub  <= op_is_sub(req.req_op);
              r_s1_prod <= w_prod;
            end
          end
        endcase
      end
    end
  end

  assign hi_o     = r_hi;
  assign lo_o     = r_lo;
  assign busy     = r_s1_vld;
  assign acc_done = r_acc_done;
endmodule

// File: tb/tb_hilo_acc.sv
// Directed checks of hilo_acc: reset, writes, signed/unsigned accumulate,
// wrap-around, flush, reset during accumulate and back-to-back throughput.
module tb_hilo_acc;
  import hilo_acc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] hi_o, lo_o;
  logic        busy, acc_done;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  hilo_acc_if #(.XLEN(32)) bus ();

  hilo_acc #(.XLEN(32), .MUL_SIGNED_EN(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.slave),
    .flush    (flush),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .busy     (busy),
    .acc_done (acc_done)
  );

  // Present one request for exactly one rising edge.
  task automatic issue(input hilo_op_e op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.req_op    = op;
    bus.hi_i      = a;
    bus.lo_i      = b;
    bus.rs_i      = a;
    bus.rt_i      = b;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({hi_o, lo_o} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h want 0", {hi_o, lo_o}); end
    checks++; if ({busy, acc_done} !== 2'b00) begin errors++; $display("FAIL reset_flags: got busy/done %b want 00", {busy, acc_done}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_write;
    issue(OP_WBOTH, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    checks++; if ({hi_o, lo_o} !== 64'h12345678_9ABCDEF0) begin errors++; $display("FAIL wboth: got %h want 123456789abcdef0", {hi_o, lo_o}); end
    issue(OP_WLO, 32'hDEAD_0000, 32'h1);
    @(negedge clk);
    checks++; if ({hi_o, lo_o} !== 64'h12345678_00000001) begin errors++; $display("FAIL wlo: got %h want 1234567800000001", {hi_o, lo_o}); end
    issue(OP_WHI, 32'hCAFE_F00D, 32'h5555);
    @(negedge clk);
    checks++; if ({hi_o, lo_o} !== 64'hCAFEF00D_00000001) begin errors++; $display("FAIL whi: got %h want cafef00d00000001", {hi_o, lo_o}); end
    issue(OP_NOP, 32'h1111_1111, 32'h2222_2222);
    @(negedge clk);
    checks++; if ({hi_o, lo_o, busy} !== {64'hCAFEF00D_00000001, 1'b0}) begin errors++; $display("FAIL nop: got %h busy %b want cafef00d00000001 busy 0", {hi_o, lo_o}, busy); end
  endtask

  task automatic test_madd_signed;
    issue(OP_WBOTH, 32'h0, 32'h5);
    issue(OP_MADD, 32'hFFFF_FFFE, 32'h3);
    @(negedge clk);
    checks++; if ({busy, acc_done, bus.req_ready} !== 3'b100) begin errors++; $display("FAIL madd_stage1: got busy/done/ready %b want 100", {busy, acc_done, bus.req_ready}); end
    checks++; if ({hi_o, lo_o} !== 64'h5) begin errors++; $display("FAIL madd_hold: got %h want 5", {hi_o, lo_o}); end
    @(negedge clk);
    checks++; if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("FAIL madd_result: got %h want ffffffffffffffff", {hi_o, lo_o}); end
    checks++; if ({busy, acc_done} !== 2'b01) begin errors++; $display("FAIL madd_done: got busy/done %b want 01", {busy, acc_done}); end
    @(negedge clk);
    checks++; if (acc_done !== 1'b0) begin errors++; $display("FAIL madd_pulse: got acc_done %b want 0", acc_done); end
    // -1 * -1 signed = +1, so 0 - 1 wraps to all ones (unsigned would differ).
    issue(OP_WBOTH, 32'h0, 32'h0);
    issue(OP_MSUB, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    checks++; if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("FAIL msub: got %h want ffffffffffffffff", {hi_o, lo_o}); end
  endtask

  task automatic test_unsigned;
    issue(OP_WBOTH, 32'h0, 32'h0);
    issue(OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    checks++; if ({hi_o, lo_o} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL maddu: got %h want fffffffe00000001", {hi_o, lo_o}); end
    issue(OP_WBOTH, 32'h0, 32'h0);
    issue(OP_MSUBU, 32'h1, 32'h1);
    repeat (2) @(negedge clk);
    checks++; if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("FAIL msubu_wrap: got %h want ffffffffffffffff", {hi_o, lo_o}); end
  endtask

  task automatic test_flush;
    issue(OP_WBOTH, 32'h0, 32'h5);
    @(negedge clk);
    bus.req_op = OP_MADD; bus.rs_i = 32'h2; bus.rt_i = 32'h3; bus.req_valid = 1'b1;
    @(negedge clk);  // accepted at the edge just passed
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_accept: got busy %b want 1", busy); end
    flush = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", bus.req_ready); end
    @(negedge clk);
    checks++; if ({hi_o, lo_o, busy, acc_done} !== {64'h5, 2'b00}) begin errors++; $display("FAIL flush_cancel: got %h busy/done %b want 5 busy/done 00", {hi_o, lo_o}, {busy, acc_done}); end
    flush = 1'b0;
    @(negedge clk);  // still-held request accepted now that ready is high
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_reaccept: got busy %b want 1", busy); end
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({hi_o, lo_o, acc_done} !== {64'hB, 1'b1}) begin errors++; $display("FAIL flush_after: got %h done %b want b done 1", {hi_o, lo_o}, acc_done); end
    // Flush while idle also blocks acceptance of a write.
    @(negedge clk);
    flush = 1'b1; bus.req_op = OP_WLO; bus.lo_i = 32'h77; bus.req_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; bus.req_valid = 1'b0;
    checks++; if (lo_o !== 32'hB) begin errors++; $display("FAIL flush_idle_write: got lo %h want b", lo_o); end
  endtask

  task automatic test_rst_inflight;
    issue(OP_WBOTH, 32'h7, 32'h9);
    issue(OP_MADDU, 32'h10, 32'h10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({hi_o, lo_o, busy, acc_done} !== {64'h0, 2'b00}) begin errors++; $display("FAIL rst_inflight: got %h busy/done %b want 0 busy/done 00", {hi_o, lo_o}, {busy, acc_done}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({hi_o, lo_o, acc_done, bus.req_ready} !== {64'h0, 2'b01}) begin errors++; $display("FAIL rst_discard: got %h done/ready %b want 0 done/ready 01", {hi_o, lo_o}, {acc_done, bus.req_ready}); end
  endtask

  task automatic test_back_to_back;
    issue(OP_WBOTH, 32'h0, 32'h0);
    @(negedge clk);
    bus.req_op = OP_MADDU; bus.rs_i = 32'h1; bus.rt_i = 32'h1; bus.req_valid = 1'b1;
    @(negedge clk);
    checks++; if ({busy, lo_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL b2b_e1: got busy %b lo %h want busy 1 lo 0", busy, lo_o); end
    @(negedge clk);
    checks++; if ({busy, acc_done, lo_o} !== {2'b01, 32'h1}) begin errors++; $display("FAIL b2b_e2: got busy/done %b lo %h want 01 lo 1", {busy, acc_done}, lo_o); end
    @(negedge clk);
    checks++; if ({busy, lo_o} !== {1'b1, 32'h1}) begin errors++; $display("FAIL b2b_e3: got busy %b lo %h want busy 1 lo 1", busy, lo_o); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++; if ({hi_o, lo_o, acc_done} !== {64'h2, 1'b1}) begin errors++; $display("FAIL b2b_e4: got %h done %b want 2 done 1", {hi_o, lo_o}, acc_done); end
    @(negedge clk);
    checks++; if ({hi_o, lo_o, busy} !== {64'h2, 1'b0}) begin errors++; $display("FAIL b2b_noqueue: got %h busy %b want 2 busy 0", {hi_o, lo_o}, busy); end
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NOP;
    bus.hi_i      = '0;
    bus.lo_i      = '0;
    bus.rs_i      = '0;
    bus.rt_i      = '0;
    test_reset();
    test_write();
    test_madd_signed();
    test_unsigned();
    test_flush();
    test_rst_inflight();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
